window_5x5_reader: RTL and testbench
====================================

# window_5x5_reader

Read-side companion to the 8-bit line buffers in the edge-detection datapath. The block accepts the camera pixel stream in raster order and keeps the four previous image rows in internal block RAM. For every interior pixel it emits one fully populated 5x5 neighbourhood, ready for the convolution/gradient stage. Border pixels get no window; windows are generated only where all 25 taps are real pixels of the current frame.

## Interface
- IMG_WIDTH, 640, pixels per row; legal range 5..1024.
- IMG_HEIGHT, 480, rows per frame; legal range 5..1024.
- clk  input  1  pixel clock; all state on the rising edge.
- reset  input  1  synchronous, active-high.
- pix_in  input  8  incoming pixel.
- pix_valid  input  1  pix_in is accepted this cycle. Every asserted cycle is accepted; there is no backpressure.
- sof  input  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- window_out  output  200  5x5 window, row-major. [199:192] is top-left, pixel (r-4,c-4). [7:0] is bottom-right, pixel (r,c).
- window_valid  output  1  single-cycle strobe; window_out, win_row and win_col are valid.
- win_row  output  10  centre row of the window (r-2).
- win_col  output  10  centre column of the window (c-2).

## Operation
- Position counters: col and row, both 10 bits, giving the position (r,c) of the next accepted pixel.
  - On an accepted pixel, col increments.
  - At col = IMG_WIDTH-1, col goes to 0 and row increments.
  - At the last pixel of the frame, both counters go to 0.
- sof with pix_valid: the pixel is treated as (0,0), whatever the counters hold. The counters then advance from (0,1).
- Line storage: four RAMs L0..L3, each IMG_WIDTH x 8, with 1-cycle synchronous read. Lk[c] holds pixel (r-1-k, c).
- Stage 1 (accept cycle): read address c is issued to all four RAMs. pix_in, c, r and a stage-1 valid flag are registered.
- Stage 2 (next cycle): the read data d0..d3 return.
  - The column vector {d3,d2,d1,d0,pix} (oldest row first) shifts into a 5-column window shift register. The newest column sits at the right.
  - The RAMs cascade at column c: L0<=pix, L1<=d0, L2<=d1, L3<=d2. d3 is discarded.
- Output register: loaded when the stage-2 valid flag is set and both r>=4 and c>=4.
  - window_out takes the updated shift register.
  - win_row = r-2, win_col = c-2.
  - window_valid = 1.
  - Otherwise window_valid = 0, and window_out, win_row and win_col hold their previous values.
- pix_valid low: no counter, RAM or shift-register update. The pipeline advances only on valid data, and bubbles propagate as window_valid = 0.
- The c>=4 gate suppresses windows whose columns wrap across a row boundary. The r>=4 gate suppresses windows that would use previous-frame RAM contents.
- RAM contents are never reset or cleared.

## Timing
- Reset values:
  - window_out = 0, window_valid = 0, win_row = 0, win_col = 0.
  - col = 0, row = 0.
  - Pipeline valid flags = 0.
- Reset mid-frame: in-flight pixels are dropped, and no window_valid is emitted for them. The next accepted pixel is (0,0).
- Latency: a pixel accepted in cycle t produces window_valid high in cycle t+2, but only if it is an interior pixel.
- Throughput: 1 window per clock under continuous pix_valid.
- Read/write hazard: the stage-2 write (column c) and the stage-1 read (column c+1) always target different addresses, because IMG_WIDTH>=5.
- sof together with reset: reset wins.
- sof while the pipeline holds data: in-flight data completes normally. The counters restart at (0,0).
- Windows per frame: (IMG_WIDTH-4)*(IMG_HEIGHT-4).

## Test plan
- Ramp image with IMG_WIDTH = IMG_HEIGHT = 8, pixel = row*8+col, continuous pix_valid, sof on the first pixel:
  - first window_valid comes 2 cycles after pixel (4,4) is accepted;
  - win_row = 2, win_col = 2;
  - top-left = 0, centre = 18, bottom-right = 36;
  - exactly 16 strobes, in raster order.
- Same image with pix_valid deasserted randomly about 40% of the time: identical window sequence and contents; window_valid never high on a bubble.
- Two back-to-back 8x8 frames, the first all 0xFF and the second all 0x00: every frame-2 window equals 0. No window appears before frame-2 pixel (4,4).
- sof asserted at frame-1 pixel (5,3): no strobes until 4 rows and 4 columns after the new origin. Then win_row = 2 and win_col = 2 relative to the new origin.
- reset pulsed one cycle after pixel (6,6) is accepted: no strobe for (6,6); all outputs read 0; the next pixel is treated as (0,0).
- Default 640x480 frame, continuous: 302736 strobes; last strobe has win_row = 477, win_col = 637.

Source files
------------

// File: rtl/window_5x5_reader.sv
// window_5x5_reader: raster-stream 5x5 neighbourhood generator.
// Four line RAMs plus a 5-column shift register feed one window per interior pixel.
module window_5x5_reader #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   pix_in,
    input  logic         pix_valid,
    input  logic         sof,
    output logic [199:0] window_out,
    output logic         window_valid,
    output logic [9:0]   win_row,
    output logic [9:0]   win_col
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [9:0] LAST_COL = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] LAST_ROW = 10'(IMG_HEIGHT - 1);

    // position of the next accepted pixel
    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] cur_col;
    logic [9:0] cur_row;
    logic [9:0] nxt_col;
    logic [9:0] nxt_row;

    // stage-1 registers
    logic       s1_valid;
    logic [7:0] s1_pix;
    logic [9:0] s1_col;
    logic [9:0] s1_row;

    // line RAMs: line_k[c] holds pixel (r-1-k, c)
    logic [7:0] line0 [IMG_WIDTH];
    logic [7:0] line1 [IMG_WIDTH];
    logic [7:0] line2 [IMG_WIDTH];
    logic [7:0] line3 [IMG_WIDTH];
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;

    // window columns, index 4 is the newest; inside a column index 0 is the oldest row
    logic [4:0][39:0] taps;
    logic [4:0][39:0] taps_next;
    logic [4:0][7:0]  column;
    logic [199:0]     win_next;
    logic             emit;

    // position of the pixel being accepted (sof forces the origin) and its successor
    always_comb begin
        cur_col = sof ? 10'd0 : col;
        cur_row = sof ? 10'd0 : row;
        nxt_col = cur_col + 10'd1;
        nxt_row = cur_row;
        if (cur_col == LAST_COL) begin
            nxt_col = 10'd0;
            nxt_row = (cur_row == LAST_ROW) ? 10'd0 : cur_row + 10'd1;
        end
    end

    // advance the raster counters on every accepted pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= 10'd0;
            row <= 10'd0;
        end else if (pix_valid) begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    // stage 1: capture the accepted pixel and its position
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_pix   <= 8'd0;
            s1_col   <= 10'd0;
            s1_row   <= 10'd0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                s1_pix <= pix_in;
                s1_col <= cur_col;
                s1_row <= cur_row;
            end
        end
    end

    // line RAMs: read-first, read at the accept column, cascade write one cycle later
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            d0 <= line0[cur_col[AW-1:0]];
            d1 <= line1[cur_col[AW-1:0]];
            d2 <= line2[cur_col[AW-1:0]];
            d3 <= line3[cur_col[AW-1:0]];
        end
        if (s1_valid && !reset) begin
            line0[s1_col[AW-1:0]] <= s1_pix;
            line1[s1_col[AW-1:0]] <= d0;
            line2[s1_col[AW-1:0]] <= d1;
            line3[s1_col[AW-1:0]] <= d2;
        end
    end

    // new column enters on the right; reorder the taps into a row-major window
    always_comb begin
        column    = {s1_pix, d0, d1, d2, d3};
        taps_next = {column, taps[4:1]};
        win_next  = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                win_next[(24 - (5 * i + j)) * 8 +: 8] = taps_next[j][i * 8 +: 8];
            end
        end
        emit = s1_valid && (s1_row >= 10'd4) && (s1_col >= 10'd4);
    end

    // stage 2: shift the window register on valid data
    always_ff @(posedge clk) begin
        if (reset) begin
            taps <= '0;
        end else if (s1_valid) begin
            taps <= taps_next;
        end
    end

    // output register: load only for windows fully inside the current frame
    always_ff @(posedge clk) begin
        if (reset) begin
            window_out   <= '0;
            window_valid <= 1'b0;
            win_row      <= 10'd0;
            win_col      <= 10'd0;
        end else begin
            window_valid <= emit;
            if (emit) begin
                window_out <= win_next;
                win_row    <= s1_row - 10'd2;
                win_col    <= s1_col - 10'd2;
            end
        end
    end

endmodule

// File: tb/tb_window_5x5_reader.sv
// tb_window_5x5_reader: random and directed stimulus against an image-array model.
// Expected windows are cut directly out of the stored frame at each interior pixel.
module tb_window_5x5_reader;

    localparam int W = 8;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         sof;
    logic [199:0] window_out;
    logic         window_valid;
    logic [9:0]   win_row;
    logic [9:0]   win_col;

    window_5x5_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk),
        .reset(reset),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .sof(sof),
        .window_out(window_out),
        .window_valid(window_valid),
        .win_row(win_row),
        .win_col(win_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [199:0] win;
        int           row;
        int           col;
    } exp_t;

    exp_t       pend[$];
    logic [7:0] img [H][W];
    int         mr = 0;
    int         mc = 0;
    int         edge_n = 0;
    int         strobes = 0;
    int         errors = 0;
    int         checks = 0;

    bit           got_first;
    int           f_edge;
    logic [9:0]   f_row;
    logic [9:0]   f_col;
    logic [199:0] f_win;

    task automatic chk(input string tag, input logic [199:0] got,
                       input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs, update the model at the edge, then compare
    task automatic cyc(input bit v, input bit s, input logic [7:0] p, input bit r);
        exp_t e;
        bit   ev;
        reset     = r;
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        @(posedge clk);
        edge_n++;
        if (r) begin
            pend.delete();
            mr = 0;
            mc = 0;
        end else if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = p;
            if (mr >= 4 && mc >= 4) begin
                e.due = edge_n + 1;
                e.row = mr - 2;
                e.col = mc - 2;
                e.win = '0;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        e.win[(24 - (5 * i + j)) * 8 +: 8] = img[mr - 4 + i][mc - 4 + j];
                pend.push_back(e);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr++;
                if (mr == H) mr = 0;
            end
        end
        #1;
        ev = (pend.size() > 0) && (pend[0].due == edge_n);
        chk("valid", window_valid, ev);
        if (window_valid) begin
            strobes++;
            if (!got_first) begin
                got_first = 1'b1;
                f_edge    = edge_n;
                f_row     = win_row;
                f_col     = win_col;
                f_win     = window_out;
            end
        end
        if (ev) begin
            e = pend.pop_front();
            if (window_valid) begin
                chk("window", window_out, e.win);
                chk("win_row", win_row, e.row);
                chk("win_col", win_col, e.col);
            end
        end
        if (r) begin
            chk("rst_window", window_out, 0);
            chk("rst_valid", window_valid, 0);
            chk("rst_row", win_row, 0);
            chk("rst_col", win_col, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic bubbles(input int pct);
        while ($urandom_range(0, 99) < pct) cyc(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        int s0;
        int acc44;
        int early;

        cyc(1'b0, 1'b0, 8'd0, 1'b1);
        cyc(1'b1, 1'b1, 8'd55, 1'b1);
        idle(3);

        // ramp frame, continuous
        got_first = 1'b0;
        s0 = strobes;
        acc44 = 0;
        for (int k = 0; k < W * H; k++) begin
            cyc(1'b1, k == 0, 8'(k), 1'b0);
            if (k == 4 * W + 4) acc44 = edge_n;
        end
        idle(3);
        chk("ramp_count", strobes - s0, 16);
        chk("ramp_latency", f_edge - acc44, 1);
        chk("ramp_row", f_row, 2);
        chk("ramp_col", f_col, 2);
        chk("ramp_tl", f_win[199:192], 0);
        chk("ramp_ctr", f_win[103:96], 18);
        chk("ramp_br", f_win[7:0], 36);

        // same ramp with ~40% bubbles
        s0 = strobes;
        for (int k = 0; k < W * H; k++) begin
            bubbles(40);
            cyc(1'b1, k == 0, 8'(k), 1'b0);
        end
        idle(4);
        chk("bubble_count", strobes - s0, 16);

        // all-0xFF frame then all-0x00 frame back to back
        for (int k = 0; k < W * H; k++) cyc(1'b1, k == 0, 8'hFF, 1'b0);
        s0 = strobes;
        early = 0;
        for (int k = 0; k < W * H; k++) begin
            cyc(1'b1, k == 0, 8'h00, 1'b0);
            if (k >= 1 && k <= 4 * W + 4 && window_valid) early++;
            if (k >= 1 && window_valid) chk("zero_win", window_out, 0);
        end
        s0 = strobes;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 8'd0, 1'b0);
            if (window_valid) chk("zero_win", window_out, 0);
        end
        chk("f2_early", early, 0);
        chk("f2_tail", strobes - s0, 1);

        // sof arriving at frame pixel (5,3)
        for (int k = 0; k < 5 * W + 3; k++) cyc(1'b1, k == 0, 8'($urandom), 1'b0);
        idle(3);
        got_first = 1'b0;
        s0 = strobes;
        early = 0;
        for (int k = 0; k < W * H; k++) begin
            cyc(1'b1, k == 0, 8'($urandom), 1'b0);
            if (k <= 4 * W + 4 && window_valid) early++;
        end
        idle(3);
        chk("sof_early", early, 0);
        chk("sof_row", f_row, 2);
        chk("sof_col", f_col, 2);
        chk("sof_count", strobes - s0, 16);

        // reset one cycle after pixel (6,6)
        for (int k = 0; k <= 6 * W + 6; k++) cyc(1'b1, k == 0, 8'($urandom), 1'b0);
        s0 = strobes;
        cyc(1'b1, 1'b0, 8'($urandom), 1'b1);
        idle(2);
        chk("rst_drop", strobes - s0, 0);
        s0 = strobes;
        for (int k = 0; k < W * H; k++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
        idle(3);
        chk("rst_next_count", strobes - s0, 16);

        // random frames, bubbles and occasional stray sof
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < W * H; k++) begin
                bubbles(30);
                cyc(1'b1, (k == 0) || ($urandom_range(0, 149) == 0),
                    8'($urandom), 1'b0);
            end
        end
        idle(4);
        chk("pend_empty", pend.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
